// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch/button debouncer.
// A single shared prescaler produces a one-clock sample tick every TICK_DIV
// cycles. Each channel synchronises its raw input through two flops, then
// confirms a level change only after N_SAMPLES consecutive ticks on which the
// synchronised input disagrees with the debounced level. Any cycle of
// agreement clears the confirm counter, so a bounce restarts confirmation.
// Press and release are symmetric; each change emits a registered one-clock
// rise_p or fall_p pulse aligned with the first cycle db shows the new level.
module debounce_multi #(
  parameter int N_CH      = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int N_SAMPLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise_p,
  output logic [N_CH-1:0] fall_p,
  output logic            tick_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(N_SAMPLES + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N_SAMPLES - 1);

  logic [PW-1:0]          pre_q, pre_d;
  logic                   tick;
  logic [N_CH-1:0]        sync1_q, sync1_d;
  logic [N_CH-1:0]        sync2_q, sync2_d;
  logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]        db_q, db_d;
  logic [N_CH-1:0]        rise_q, rise_d;
  logic [N_CH-1:0]        fall_q, fall_d;

  // Prescaler: count 0..TICK_DIV-1, tick decoded combinationally on the last count.
  always_comb begin
    tick  = (pre_q == P_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Two-flop synchroniser input chain; sync2_q is the only view of sw used downstream.
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
  end

  // Per-channel confirm logic: clear on agreement, count disagreeing ticks, flip db on the last one.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == C_LAST) begin
          cnt_d[i]  = '0;
          db_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // State registers; asynchronous reset clears all progress and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db     = db_q;
  assign rise_p = rise_q;
  assign fall_p = fall_q;
  assign tick_o = tick;

endmodule
